// File: rtl/nf_ahb_arbiter.sv
// Two-master to one-slave AHB-lite arbiter: round-robin grant, one transfer at a time,
// data phase bounded by a wait counter that turns a stalled slave into an ERROR completion.
module nf_ahb_arbiter #(
  parameter int timeout = 16
) (
  input  logic        hclk,
  input  logic        hresetn,

  input  logic [31:0] haddr_m0,
  input  logic [31:0] hwdata_m0,
  input  logic        hwrite_m0,
  input  logic [1:0]  htrans_m0,
  input  logic [2:0]  hsize_m0,
  input  logic [2:0]  hburst_m0,
  output logic [31:0] hrdata_m0,
  output logic [1:0]  hresp_m0,
  output logic        hready_m0,

  input  logic [31:0] haddr_m1,
  input  logic [31:0] hwdata_m1,
  input  logic        hwrite_m1,
  input  logic [1:0]  htrans_m1,
  input  logic [2:0]  hsize_m1,
  input  logic [2:0]  hburst_m1,
  output logic [31:0] hrdata_m1,
  output logic [1:0]  hresp_m1,
  output logic        hready_m1,

  output logic [31:0] haddr_s,
  output logic [31:0] hwdata_s,
  output logic        hwrite_s,
  output logic [1:0]  htrans_s,
  output logic [2:0]  hsize_s,
  output logic [2:0]  hburst_s,
  output logic        hsel_s,
  input  logic [31:0] hrdata_s,
  input  logic [1:0]  hresp_s,
  input  logic        hready_s
);

  localparam int         CW         = $clog2(timeout) + 1;
  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {IDLE, DATA0, DATA1} state_t;

  state_t        state_reg;
  logic          last_grant_reg;
  logic [CW-1:0] cnt_reg;

  logic [1:0] req;
  logic       grant_valid;
  logic       grant_idx;
  logic       in_data;
  logic       data_idx;
  logic       timed_out;
  logic       done;

  assign req = {htrans_m1 != TRANS_IDLE, htrans_m0 != TRANS_IDLE};

  // Arbitration only happens in IDLE; the reset gate keeps the slave quiet while held in reset.
  assign grant_valid = hresetn && (state_reg == IDLE) && (req != 2'b00);
  assign grant_idx   = (req == 2'b11) ? ~last_grant_reg : req[1];

  assign in_data   = (state_reg != IDLE);
  assign data_idx  = (state_reg == DATA1);
  assign timed_out = in_data && !hready_s && (cnt_reg == CW'(timeout - 1));
  assign done      = in_data && (hready_s || timed_out);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            state_reg      <= grant_idx ? DATA1 : DATA0;
            last_grant_reg <= grant_idx;
            cnt_reg        <= '0;
          end
        end
        DATA0, DATA1: begin
          if (done) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    haddr_s  = '0;
    hwdata_s = '0;
    hwrite_s = 1'b0;
    htrans_s = TRANS_IDLE;
    hsize_s  = '0;
    hburst_s = '0;
    hsel_s   = 1'b0;
    if (grant_valid) begin
      hsel_s = 1'b1;
      if (grant_idx) begin
        haddr_s  = haddr_m1;
        hwrite_s = hwrite_m1;
        htrans_s = htrans_m1;
        hsize_s  = hsize_m1;
        hburst_s = hburst_m1;
      end else begin
        haddr_s  = haddr_m0;
        hwrite_s = hwrite_m0;
        htrans_s = htrans_m0;
        hsize_s  = hsize_m0;
        hburst_s = hburst_m0;
      end
    end
    if (in_data) begin
      hwdata_s = data_idx ? hwdata_m1 : hwdata_m0;
    end
  end

  logic [1:0]  hready_m;
  logic [1:0]  hresp_m  [2];
  logic [31:0] hrdata_m [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic done_here;
      assign done_here    = done && (data_idx == (gi == 1));
      assign hready_m[gi] = !req[gi] || done_here;
      assign hresp_m[gi]  = done_here ? (timed_out ? RESP_ERROR : hresp_s) : RESP_OKAY;
      assign hrdata_m[gi] = (done_here && !timed_out) ? hrdata_s : '0;
    end
  endgenerate

  assign hready_m0 = hready_m[0];
  assign hready_m1 = hready_m[1];
  assign hresp_m0  = hresp_m[0];
  assign hresp_m1  = hresp_m[1];
  assign hrdata_m0 = hrdata_m[0];
  assign hrdata_m1 = hrdata_m[1];

endmodule

// File: tb/tb_nf_ahb_arbiter.sv
// Bench for nf_ahb_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model of who owns the slave and how long it has waited.
module tb_nf_ahb_arbiter;

  localparam int TIMEOUT = 16;

  logic        hclk = 1'b0;
  logic        hresetn;

  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        m_write [2];
  logic [1:0]  m_trans [2];
  logic [2:0]  m_size  [2];
  logic [2:0]  m_burst [2];

  logic [31:0] hrdata_m [2];
  logic [1:0]  hresp_m  [2];
  logic        hready_m [2];

  logic [31:0] haddr_s, hwdata_s;
  logic        hwrite_s, hsel_s;
  logic [1:0]  htrans_s;
  logic [2:0]  hsize_s, hburst_s;

  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  logic        s_ready;

  always #5 hclk = ~hclk;

  nf_ahb_arbiter #(.timeout(TIMEOUT)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .haddr_m0  (m_addr[0]),
    .hwdata_m0 (m_wdata[0]),
    .hwrite_m0 (m_write[0]),
    .htrans_m0 (m_trans[0]),
    .hsize_m0  (m_size[0]),
    .hburst_m0 (m_burst[0]),
    .hrdata_m0 (hrdata_m[0]),
    .hresp_m0  (hresp_m[0]),
    .hready_m0 (hready_m[0]),
    .haddr_m1  (m_addr[1]),
    .hwdata_m1 (m_wdata[1]),
    .hwrite_m1 (m_write[1]),
    .htrans_m1 (m_trans[1]),
    .hsize_m1  (m_size[1]),
    .hburst_m1 (m_burst[1]),
    .hrdata_m1 (hrdata_m[1]),
    .hresp_m1  (hresp_m[1]),
    .hready_m1 (hready_m[1]),
    .haddr_s   (haddr_s),
    .hwdata_s  (hwdata_s),
    .hwrite_s  (hwrite_s),
    .htrans_s  (htrans_s),
    .hsize_s   (hsize_s),
    .hburst_s  (hburst_s),
    .hsel_s    (hsel_s),
    .hrdata_s  (s_rdata),
    .hresp_s   (s_resp),
    .hready_s  (s_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner of the slave (-1 = none), cycles waited, last granted master.
  int owner  = -1;
  int waited = 0;
  int last   = 1;
  bit g_valid;
  int g_idx;
  bit cmpl;
  bit m_done [2];

  task automatic model_check();
    bit          req    [2];
    bit          e_ready[2];
    logic [1:0]  e_resp [2];
    logic [31:0] e_rdata[2];
    logic [31:0] e_haddr, e_hwdata;
    logic        e_hwrite, e_hsel;
    logic [1:0]  e_htrans;
    logic [2:0]  e_hsize, e_hburst;
    e_haddr = '0; e_hwdata = '0; e_hwrite = 1'b0; e_hsel = 1'b0;
    e_htrans = 2'b00; e_hsize = '0; e_hburst = '0;
    g_valid = 1'b0; g_idx = 0; cmpl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i]     = (m_trans[i] != 2'b00);
      e_ready[i] = !req[i];
      e_resp[i]  = 2'b00;
      e_rdata[i] = '0;
      m_done[i]  = 1'b0;
    end
    if (hresetn) begin
      if (owner < 0) begin
        if (req[0] || req[1]) begin
          g_valid  = 1'b1;
          g_idx    = (req[0] && req[1]) ? 1 - last : (req[0] ? 0 : 1);
          e_hsel   = 1'b1;
          e_haddr  = m_addr[g_idx];
          e_hwrite = m_write[g_idx];
          e_htrans = m_trans[g_idx];
          e_hsize  = m_size[g_idx];
          e_hburst = m_burst[g_idx];
        end
      end else begin
        cmpl     = s_ready || (waited == TIMEOUT - 1);
        e_hwdata = m_wdata[owner];
        if (cmpl) begin
          e_ready[owner] = 1'b1;
          m_done[owner]  = 1'b1;
          e_resp[owner]  = s_ready ? s_resp : 2'b01;
          e_rdata[owner] = s_ready ? s_rdata : 32'h0;
        end
      end
    end
    check("hsel_s",    {31'h0, hsel_s},      {31'h0, e_hsel});
    check("haddr_s",   haddr_s,              e_haddr);
    check("hwrite_s",  {31'h0, hwrite_s},    {31'h0, e_hwrite});
    check("htrans_s",  {30'h0, htrans_s},    {30'h0, e_htrans});
    check("hsize_s",   {29'h0, hsize_s},     {29'h0, e_hsize});
    check("hburst_s",  {29'h0, hburst_s},    {29'h0, e_hburst});
    check("hwdata_s",  hwdata_s,             e_hwdata);
    check("hready_m0", {31'h0, hready_m[0]}, {31'h0, e_ready[0]});
    check("hready_m1", {31'h0, hready_m[1]}, {31'h0, e_ready[1]});
    check("hresp_m0",  {30'h0, hresp_m[0]},  {30'h0, e_resp[0]});
    check("hresp_m1",  {30'h0, hresp_m[1]},  {30'h0, e_resp[1]});
    check("hrdata_m0", hrdata_m[0],          e_rdata[0]);
    check("hrdata_m1", hrdata_m[1],          e_rdata[1]);
  endtask

  task automatic model_update();
    if (!hresetn) begin
      owner = -1; waited = 0; last = 1;
    end else if (owner < 0) begin
      if (g_valid) begin
        owner = g_idx; last = g_idx; waited = 0;
      end
    end else if (cmpl) begin
      owner = -1;
    end else begin
      waited++;
    end
  endtask

  // Compare on the falling edge, advance the model on the rising edge, return just after it.
  task automatic step();
    @(negedge hclk);
    model_check();
    @(posedge hclk);
    model_update();
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wr);
    m_trans[i] = 2'b10;
    m_addr[i]  = addr;
    m_wdata[i] = wdata;
    m_write[i] = wr;
    m_size[i]  = 3'b010;
    m_burst[i] = 3'b000;
  endtask

  task automatic rand_masters(input int pct);
    for (int i = 0; i < 2; i++) begin
      if (m_trans[i] == 2'b00 || m_done[i]) begin
        m_addr[i]  = $urandom;
        m_wdata[i] = $urandom;
        m_write[i] = 1'($urandom_range(1));
        m_size[i]  = 3'($urandom_range(7));
        m_burst[i] = 3'($urandom_range(7));
        if (int'($urandom_range(99)) < pct)
          m_trans[i] = ($urandom_range(1) != 0) ? 2'b10 : 2'b11;
        else
          m_trans[i] = 2'b00;
      end
    end
  endtask

  initial begin
    hresetn = 1'b0;
    s_ready = 1'b1; s_rdata = '0; s_resp = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_trans[i] = 2'b00; m_addr[i] = '0; m_wdata[i] = '0;
      m_write[i] = 1'b0; m_size[i] = '0; m_burst[i] = '0;
      m_done[i] = 1'b0;
    end
    #1;
    step();
    step();
    set_req(0, 32'h1234_5678, 32'h0, 1'b0);   // request while in reset: no slave activity
    step();
    m_trans[0] = 2'b00;
    hresetn = 1'b1;
    step();

    // Single read from m0, slave answers on the first data cycle
    set_req(0, 32'h0001_0004, 32'h0, 1'b0);
    s_ready = 1'b1; s_rdata = 32'h0000_00A5; s_resp = 2'b00;
    step();
    step();
    m_trans[0] = 2'b00;
    step();

    // Write from m1 with two slave wait states
    set_req(1, 32'h0001_0000, 32'h0000_00FF, 1'b1);
    step();
    s_ready = 1'b0;
    step();
    step();
    s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
    step();
    m_trans[1] = 2'b00;
    step();

    // Continuous contention: grants alternate
    set_req(0, 32'hA000_0000, 32'h1111_1111, 1'b1);
    set_req(1, 32'hB000_0000, 32'h2222_2222, 1'b0);
    s_ready = 1'b1; s_rdata = 32'h0000_5A5A;
    for (int k = 0; k < 12; k++) step();
    m_trans[0] = 2'b00; m_trans[1] = 2'b00;
    step();
    step();

    // Stalled slave: ERROR completion after TIMEOUT data cycles
    set_req(0, 32'h0000_0040, 32'h0, 1'b0);
    s_ready = 1'b0; s_rdata = 32'hFFFF_FFFF; s_resp = 2'b00;
    for (int k = 0; k < TIMEOUT + 4; k++) begin
      step();
      if (m_done[0]) m_trans[0] = 2'b00;
    end

    // Reset during DATA1, then a tie after release goes to m0
    set_req(1, 32'h0000_0080, 32'h0000_0077, 1'b1);
    step();
    step();
    hresetn = 1'b0;
    set_req(0, 32'h0000_00C0, 32'h0000_0066, 1'b0);
    step();
    step();
    hresetn = 1'b1;
    s_ready = 1'b1; s_rdata = 32'h0000_0033;
    for (int k = 0; k < 6; k++) step();
    m_trans[0] = 2'b00; m_trans[1] = 2'b00;
    step();

    // Random traffic with stall bursts and occasional resets
    for (int k = 0; k < 3000; k++) begin
      rand_masters(60);
      if ((k % 250) >= 220) s_ready = 1'b0;
      else                  s_ready = ($urandom_range(99) < 70);
      s_rdata = $urandom;
      s_resp  = 2'($urandom_range(3));
      if (hresetn && $urandom_range(299) == 0) hresetn = 1'b0;
      else if (!hresetn && $urandom_range(1) == 0) hresetn = 1'b1;
      step();
    end
    hresetn = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
